// File: rtl/common_dffram_1w_nr_sync_pkg.sv
// Shared helpers for the DFF-based RAM with flash-clearable valid bits.
// Write-first read bypass is enabled by defining COMMON_DFFRAM_BYPASS_EN (left undefined by default).
package common_dffram_1w_nr_sync_pkg;

   function automatic int unsigned ram_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/common_dffram_rdport.sv
// One registered read port: address mux, optional write-first merge, enable-gated output.
// The merge path and its extra ports exist only when COMMON_DFFRAM_BYPASS_EN is defined.
module common_dffram_rdport
   import common_dffram_1w_nr_sync_pkg::*;
#(
   parameter int unsigned RAM_DATA_WIDTH = 1,
   parameter int unsigned RAM_ADDR_WIDTH = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [RAM_ADDR_WIDTH-1:0] addr,
   input  logic [RAM_DATA_WIDTH-1:0] mem [ram_depth(RAM_ADDR_WIDTH)],
   input  logic [ram_depth(RAM_ADDR_WIDTH)-1:0] valid,
`ifdef COMMON_DFFRAM_BYPASS_EN
   input  logic                      wr_en,
   input  logic [RAM_ADDR_WIDTH-1:0] wr_addr,
   input  logic [RAM_DATA_WIDTH-1:0] wr_mask,
   input  logic [RAM_DATA_WIDTH-1:0] wr_data,
   input  logic                      clr,
`endif
   output logic [RAM_DATA_WIDTH-1:0] dout,
   output logic                      vout
);

   logic [RAM_DATA_WIDTH-1:0] rd_data;
   logic                      rd_valid;

   always_comb begin
      rd_data  = mem[addr];
      rd_valid = valid[addr];
`ifdef COMMON_DFFRAM_BYPASS_EN
      // A same-address write with an empty mask still counts as a hit for data,
      // but only a non-empty mask may override the clear on the valid bit.
      if (wr_en && (wr_addr == addr)) begin
         rd_data = (wr_data & wr_mask) | (rd_data & ~wr_mask);
      end
      if (wr_en && (wr_addr == addr) && (|wr_mask)) begin
         rd_valid = 1'b1;
      end else if (clr) begin
         rd_valid = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= '0;
         vout <= 1'b0;
      end else if (en) begin
         dout <= rd_data;
         vout <= rd_valid;
      end
   end

endmodule

// File: rtl/stdmacro_dffbe.sv
// Register with per-bit enables and a synchronous, active-high reset to a fixed value.
module stdmacro_dffbe #(
   parameter int unsigned         WIDTH       = 1,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else begin
         q <= (d & en) | (q & ~en);
      end
   end

endmodule

// File: rtl/common_dffram_1w_nr_sync.sv
// DFF RAM: one bit-masked write port, NUM_RD_PORTS registered read ports, flash-clear valid bits.
// Define COMMON_DFFRAM_BYPASS_EN for write-first reads; default is read-before-write/clear.
module common_dffram_1w_nr_sync
   import common_dffram_1w_nr_sync_pkg::*;
#(
   parameter int unsigned RAM_DATA_WIDTH = 1,
   parameter int unsigned RAM_ADDR_WIDTH = 1,
   parameter int unsigned NUM_RD_PORTS   = 2,
   parameter logic [ram_depth(RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [RAM_ADDR_WIDTH-1:0]              addra,
   input  logic                                   ena,
   input  logic [RAM_DATA_WIDTH-1:0]              wea,
   input  logic [RAM_DATA_WIDTH-1:0]              dina,
   input  logic                                   clr,
   input  logic [NUM_RD_PORTS-1:0]                enb,
   input  logic [NUM_RD_PORTS*RAM_ADDR_WIDTH-1:0] addrb,
   output logic [NUM_RD_PORTS*RAM_DATA_WIDTH-1:0] doutb,
   output logic [NUM_RD_PORTS-1:0]                validb
);

   localparam int unsigned DEPTH = ram_depth(RAM_ADDR_WIDTH);
   localparam int unsigned DW    = RAM_DATA_WIDTH;
   localparam int unsigned AW    = RAM_ADDR_WIDTH;

   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] valid;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      stdmacro_dffbe #(
         .WIDTH       (DW),
         .RESET_VALUE (RAM_RESET_VALUE[i*DW +: DW])
      ) u_entry (
         .clk   (clk),
         .reset (reset),
         .en    (wea & {DW{ena && (addra == AW'(i))}}),
         .d     (dina),
         .q     (mem[i])
      );
   end

   // The write is applied after the clear so a same-cycle write leaves its entry valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
      end else begin
         if (clr) begin
            valid <= '0;
         end
         if (ena && (|wea)) begin
            valid[addra] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      common_dffram_rdport #(
         .RAM_DATA_WIDTH (DW),
         .RAM_ADDR_WIDTH (AW)
      ) u_rdport (
         .clk     (clk),
         .reset   (reset),
         .en      (enb[k]),
         .addr    (addrb[k*AW +: AW]),
         .mem     (mem),
         .valid   (valid),
`ifdef COMMON_DFFRAM_BYPASS_EN
         .wr_en   (ena),
         .wr_addr (addra),
         .wr_mask (wea),
         .wr_data (dina),
         .clr     (clr),
`endif
         .dout    (doutb[k*DW +: DW]),
         .vout    (validb[k])
      );
   end

endmodule

// File: tb/tb_common_dffram_1w_nr_sync.sv
// Scoreboard bench for common_dffram_1w_nr_sync (AW=2, DW=8, two read ports).
// Honours COMMON_DFFRAM_BYPASS_EN in its reference model.
module tb_common_dffram_1w_nr_sync;

   localparam logic [31:0] IMG = 32'h44332211;

   logic        clk = 1'b0;
   logic        reset, ena, clr;
   logic [1:0]  addra, enb;
   logic [7:0]  wea, dina;
   logic [3:0]  addrb;
   logic [15:0] doutb;
   logic [1:0]  validb;

   common_dffram_1w_nr_sync #(
      .RAM_DATA_WIDTH  (8),
      .RAM_ADDR_WIDTH  (2),
      .NUM_RD_PORTS    (2),
      .RAM_RESET_VALUE (IMG)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .addra  (addra),
      .ena    (ena),
      .wea    (wea),
      .dina   (dina),
      .clr    (clr),
      .enb    (enb),
      .addrb  (addrb),
      .doutb  (doutb),
      .validb (validb)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int unsigned port;
      logic [7:0]  d;
      logic        v;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks = 0;
   int unsigned errors = 0;

   // reference model state
   logic [7:0] m_mem [4];
   logic [3:0] m_vld;
   logic [7:0] m_out [2];
   logic       m_vout[2];

   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (doutb[e.port*8 +: 8] !== e.d || validb[e.port] !== e.v) begin
               errors++;
               $display("FAIL sb_port%0d: got data %h valid %b, expected data %h valid %b",
                        e.port, doutb[e.port*8 +: 8], validb[e.port], e.d, e.v);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus; starts and ends at a falling edge.
   task automatic cycle(input logic rst, input logic e, input logic [1:0] aa,
                        input logic [7:0] we, input logic [7:0] di, input logic c,
                        input logic [1:0] eb, input logic [1:0] a0, input logic [1:0] a1);
      logic [7:0] xd[2];
      logic       xv[2];
      logic [1:0] ab[2];
      reset = rst; ena = e; addra = aa; wea = we; dina = di; clr = c;
      enb = eb; addrb = {a1, a0};
      ab[0] = a0; ab[1] = a1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            xd[k] = 8'h00; xv[k] = 1'b0;
         end else if (eb[k]) begin
            xd[k] = m_mem[ab[k]];
            xv[k] = m_vld[ab[k]];
`ifdef COMMON_DFFRAM_BYPASS_EN
            if (e && ab[k] == aa) xd[k] = (di & we) | (xd[k] & ~we);
            if (e && ab[k] == aa && we != 8'h00) xv[k] = 1'b1;
            else if (c) xv[k] = 1'b0;
`endif
         end else begin
            xd[k] = m_out[k]; xv[k] = m_vout[k];
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         sb.push_back('{port: k, d: xd[k], v: xv[k]});
         m_out[k] = xd[k]; m_vout[k] = xv[k];
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) m_mem[i] = IMG[i*8 +: 8];
         m_vld = 4'h0;
      end else begin
         if (c) m_vld = 4'h0;
         if (e) begin
            m_mem[aa] = (di & we) | (m_mem[aa] & ~we);
            if (we != 8'h00) m_vld[aa] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] a0, input logic [1:0] a1);
      cycle(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'b11, a0, a1);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_mem[i] = 8'hxx;
      m_vld = 4'hx;
      for (int k = 0; k < 2; k++) begin m_out[k] = 8'hxx; m_vout[k] = 1'bx; end
      reset = 1'b1; ena = 1'b0; addra = '0; wea = '0; dina = '0; clr = 1'b0;
      enb = '0; addrb = '0;
      @(negedge clk);

      // reset image
      cycle(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'b00, 2'd0, 2'd0);
      chk("reset_out", {doutb, 6'd0, validb}, 24'h0);
      cycle(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'b00, 2'd0, 2'd0);
      rd(2'd0, 2'd1);
      chk("img_01", doutb, 16'h2211);
      chk("img_01_v", {14'd0, validb}, 16'h0);
      rd(2'd2, 2'd3);
      chk("img_23", doutb, 16'h4433);

      // masked write, then empty-mask write
      cycle(1'b0, 1'b1, 2'd1, 8'h0F, 8'hAB, 1'b0, 2'b00, 2'd0, 2'd0);
      rd(2'd1, 2'd1);
      chk("mask_wr", {doutb, 6'd0, validb}, 24'h2B2B03);
      cycle(1'b0, 1'b1, 2'd1, 8'h00, 8'hFF, 1'b0, 2'b00, 2'd0, 2'd0);
      rd(2'd1, 2'd1);
      chk("zero_mask", {doutb, 6'd0, validb}, 24'h2B2B03);

      // same-cycle write and read of addr 2
      cycle(1'b0, 1'b1, 2'd2, 8'hFF, 8'h5A, 1'b0, 2'b01, 2'd2, 2'd0);
`ifdef COMMON_DFFRAM_BYPASS_EN
      chk("collide", {8'd0, doutb[7:0], 7'd0, validb[0]}, 24'h005A01);
`else
      chk("collide", {8'd0, doutb[7:0], 7'd0, validb[0]}, 24'h003300);
`endif
      rd(2'd2, 2'd2);
      chk("after_collide", {doutb, 6'd0, validb}, 24'h5A5A03);

      // make all valid, then clear with a write to addr 3
      cycle(1'b0, 1'b1, 2'd0, 8'hFF, 8'hC0, 1'b0, 2'b00, 2'd0, 2'd0);
      cycle(1'b0, 1'b1, 2'd3, 8'hFF, 8'hD3, 1'b0, 2'b00, 2'd0, 2'd0);
      cycle(1'b0, 1'b1, 2'd3, 8'hFF, 8'h77, 1'b1, 2'b00, 2'd0, 2'd0);
      rd(2'd0, 2'd1);
      chk("clr_01", {doutb, 6'd0, validb}, 24'h2BC000);
      rd(2'd2, 2'd3);
      chk("clr_23", {doutb, 6'd0, validb}, 24'h775A02);

      // port 1 holds while port 0 tracks writes
      rd(2'd0, 2'd1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 2'(i % 2), 8'hFF, 8'(8'h90 + i), 1'b0, 2'b01, 2'd0, 2'd1);
         chk("hold_p1", {doutb[15:8], 7'd0, validb[1]}, 16'h2B00);
      end

      // reset during a write
      cycle(1'b1, 1'b1, 2'd0, 8'hFF, 8'hEE, 1'b0, 2'b11, 2'd0, 2'd1);
      chk("rst_wr_out", {doutb, 6'd0, validb}, 24'h0);
      rd(2'd0, 2'd1);
      chk("rst_img_01", doutb, 16'h2211);
      rd(2'd2, 2'd3);
      chk("rst_img_23", {doutb, 6'd0, validb}, 24'h443300);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 39) == 0), 1'($urandom()), 2'($urandom()),
               ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom()), 8'($urandom()),
               1'($urandom_range(0, 7) == 0), 2'($urandom()), 2'($urandom()), 2'($urandom()));
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
